// File: rtl/cci_mpf_shim_wro_filter_clear.sv
// Response-side half of write/read ordering: one-bit-per-hash filter with buffered removes.
// Test latency 2 cycles, fully pipelined; remove buffer is throttled by remove_almFull.
module cci_mpf_shim_wro_filter_clear #(
  parameter int N_HASH_BITS       = 14,
  parameter int REMOVE_FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rdy,
  input  logic                   test_en,
  input  logic [N_HASH_BITS-1:0] test_hash,
  output logic                   test_valid,
  output logic                   test_notPresent,
  input  logic                   insert_en,
  input  logic [N_HASH_BITS-1:0] insert_hash,
  input  logic                   remove_en,
  input  logic [N_HASH_BITS-1:0] remove_hash,
  output logic                   remove_almFull,
  output logic                   err_dup
);

  localparam int N_ENTRIES = 1 << N_HASH_BITS;
  localparam int PTR_W     = $clog2(REMOVE_FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] ALM_LVL  = CNT_W'(REMOVE_FIFO_DEPTH - 2);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(REMOVE_FIFO_DEPTH);

  typedef logic [N_HASH_BITS-1:0] hash_t;
  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t state;
  hash_t  init_idx;
  logic   ready;

  logic filter [N_ENTRIES];
  logic rd_bit;

  hash_t                  fifo_dat [REMOVE_FIFO_DEPTH];
  logic [REMOVE_FIFO_DEPTH-1:0] fifo_vld;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_full;
  logic                   push;
  logic                   drop;

  logic  wr_en;
  hash_t wr_addr;
  logic  wr_dat;
  logic  do_pop;

  logic  inflight_vld;
  hash_t inflight_hash;

  logic  s0_hit;
  logic  s1_vld;
  logic  s1_hit;
  hash_t s1_hash;
  logic  s1_ins_hit;

  assign ready          = (state == ST_READY);
  assign fifo_full      = (fifo_cnt == FULL_LVL);
  assign push           = ready && remove_en && !fifo_full;
  assign drop           = ready && remove_en && fifo_full;
  assign remove_almFull = (fifo_cnt >= ALM_LVL);

  // Single write port: init, then insert, then drain of one queued remove.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_idx;
    wr_dat  = 1'b0;
    do_pop  = 1'b0;
    if (!ready) begin
      wr_en = 1'b1;
    end else if (insert_en) begin
      wr_en   = 1'b1;
      wr_addr = insert_hash;
      wr_dat  = 1'b1;
    end else if (fifo_cnt != '0) begin
      wr_en   = 1'b1;
      do_pop  = 1'b1;
      wr_addr = fifo_dat[rd_ptr];
    end
  end

  // Conservative match: anything that will soon clear still counts as busy.
  always_comb begin
    s0_hit = (inflight_vld && inflight_hash == test_hash) ||
             (insert_en && insert_hash == test_hash);
    for (int i = 0; i < REMOVE_FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && fifo_dat[i] == test_hash) s0_hit = 1'b1;
    end
  end

  assign s1_ins_hit = insert_en && (insert_hash == s1_hash);

  always_ff @(posedge clk) begin
    if (wr_en) filter[wr_addr] <= wr_dat;
    rd_bit <= filter[test_hash];
    if (push) fifo_dat[wr_ptr] <= remove_hash;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      fifo_vld <= '0;
    end else begin
      if (push) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_INIT;
      init_idx        <= '0;
      rdy             <= 1'b0;
      s1_vld          <= 1'b0;
      s1_hit          <= 1'b0;
      s1_hash         <= '0;
      test_valid      <= 1'b0;
      test_notPresent <= 1'b0;
      inflight_vld    <= 1'b0;
      inflight_hash   <= '0;
      err_dup         <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == {N_HASH_BITS{1'b1}}) begin
            state <= ST_READY;
            rdy   <= 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase

      s1_vld          <= test_en && ready;
      s1_hash         <= test_hash;
      s1_hit          <= s0_hit;
      test_valid      <= s1_vld;
      test_notPresent <= s1_vld && !(rd_bit || s1_hit || s1_ins_hit);

      inflight_vld  <= do_pop;
      inflight_hash <= wr_addr;

      // Popping an already-clear entry means a response had no matching request.
      if (drop || (do_pop && !filter[wr_addr])) err_dup <= 1'b1;
    end
  end

endmodule
